// File: rtl/deal_scheduler_if.sv
// Bundle between the round FSM / card source (master side) and deal_scheduler (slave side).
// Card handshake: card_req stays high while a card is wanted; a card transfers on every
// cycle where card_req and card_valid are both high; shuffle_req likewise holds until shuffle_done.
interface deal_scheduler_if;
   logic [5:0] load_req;
   logic       new_round;
   logic       card_valid;
   logic [3:0] card_in;
   logic       shuffle_done;
   logic       card_req;
   logic       shuffle_req;
   logic [5:0] hand_we;
   logic [3:0] hand_card;
   logic [5:0] shoe_count;
   logic       busy;
   logic       err_badcard;
   logic       timeout;
   logic [2:0] state_dbg;

   modport master (
      output load_req, new_round, card_valid, card_in, shuffle_done,
      input  card_req, shuffle_req, hand_we, hand_card, shoe_count, busy,
             err_badcard, timeout, state_dbg
   );

   modport slave (
      input  load_req, new_round, card_valid, card_in, shuffle_done,
      output card_req, shuffle_req, hand_we, hand_card, shoe_count, busy,
             err_badcard, timeout, state_dbg
   );
endinterface

// File: rtl/deal_scheduler.sv
// Arbitrates the six hand-card loads onto one card source, tracks the shoe and reshuffles.
// Optional BURN_CARD_EN: discard one card after every reshuffle before dealing resumes.
module deal_scheduler #(
   parameter int SHOE_CARDS = 52,
   parameter int TIMEOUT    = 15
) (
   input  logic             slow_clock,
   input  logic             reset,
   deal_scheduler_if.slave  bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQ     = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_SHUFFLE = 3'd3;
`ifdef BURN_CARD_EN
   localparam logic [2:0] S_BURN    = 3'd4;
`endif

   localparam logic [5:0] SHOE_FULL = 6'(SHOE_CARDS);
   localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);

   logic [2:0] state_q, state_d;
   logic [5:0] pending_q, pending_d;
   logic [5:0] grant_q, grant_d;
   logic [3:0] card_q, card_d;
   logic [5:0] shoe_q, shoe_d;
   logic [7:0] wait_q, wait_d;
   logic       timeout_q, timeout_d;

   logic       card_legal;
   logic       card_ok;
   logic       fetching;
   logic       flush_exempt;
   logic [5:0] clr;

   // Deal order: pcard1, dcard1, pcard2, dcard2, pcard3, dcard3.
   function automatic logic [5:0] pick_grant(input logic [5:0] p);
      logic [5:0] g;
      g = 6'b000000;
      if      (p[0]) g = 6'b000001;
      else if (p[3]) g = 6'b001000;
      else if (p[1]) g = 6'b000010;
      else if (p[4]) g = 6'b010000;
      else if (p[2]) g = 6'b000100;
      else if (p[5]) g = 6'b100000;
      return g;
   endfunction

   assign card_legal = (bus.card_in != 4'd0) && (bus.card_in <= 4'd13);
   assign card_ok    = bus.card_valid && card_legal;

`ifdef BURN_CARD_EN
   assign fetching     = (state_q == S_REQ) || (state_q == S_BURN);
   assign flush_exempt = (state_q == S_SHUFFLE) || (state_q == S_BURN);
`else
   assign fetching     = (state_q == S_REQ);
   assign flush_exempt = (state_q == S_SHUFFLE);
`endif

   assign clr = (state_q == S_WRITE) ? grant_q : 6'b000000;

   always_comb begin
      state_d   = state_q;
      pending_d = (pending_q & ~clr) | bus.load_req;
      grant_d   = grant_q;
      card_d    = card_q;
      shoe_d    = shoe_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (shoe_q == 6'd0) begin
               state_d = S_SHUFFLE;
            end else if (pending_q != 6'b000000) begin
               grant_d = pick_grant(pending_q);
               wait_d  = 8'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.card_valid) begin
               wait_d = 8'd0;
               if (card_legal) begin
                  card_d  = bus.card_in;
                  state_d = S_WRITE;
               end
            end else if (wait_q != WAIT_MAX) begin
               wait_d = wait_q + 8'd1;
               if (wait_q + 8'd1 == WAIT_MAX) timeout_d = 1'b1;
            end
         end
         S_WRITE: begin
            shoe_d  = shoe_q - 6'd1;
            state_d = S_IDLE;
         end
         S_SHUFFLE: begin
            if (bus.shuffle_done) begin
               shoe_d  = SHOE_FULL;
`ifdef BURN_CARD_EN
               state_d = S_BURN;
`else
               state_d = S_IDLE;
`endif
            end
         end
`ifdef BURN_CARD_EN
         S_BURN: begin
            if (card_ok) begin
               shoe_d  = shoe_q - 6'd1;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // A legal card taken during the flush cycle has left the shoe even though it is dropped.
      if (bus.new_round) begin
         pending_d = bus.load_req;
         timeout_d = 1'b0;
         if (!flush_exempt) state_d = S_IDLE;
         if ((state_q == S_REQ) && card_ok) shoe_d = shoe_q - 6'd1;
      end
   end

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pending_q <= 6'b000000;
         grant_q   <= 6'b000000;
         card_q    <= 4'd0;
         shoe_q    <= SHOE_FULL;
         wait_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         card_q    <= card_d;
         shoe_q    <= shoe_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.card_req    = fetching;
   assign bus.shuffle_req = (state_q == S_SHUFFLE);
   assign bus.hand_we     = ((state_q == S_WRITE) && !bus.new_round) ? grant_q : 6'b000000;
   assign bus.hand_card   = (bus.hand_we != 6'b000000) ? card_q : 4'd0;
   assign bus.shoe_count  = shoe_q;
   assign bus.busy        = (state_q != S_IDLE) || (pending_q != 6'b000000);
   assign bus.err_badcard = fetching && bus.card_valid && !card_legal;
   assign bus.timeout     = timeout_q;
   assign bus.state_dbg   = state_q;

endmodule
